// File: rtl/ram_responder.sv
// Single-port RAM target for the a/d/q/rd/wr bus with programmable wait states.
// Optional RAM_INIT_CLEAR_EN: zero the whole array after every reset release.
module ram_responder #(
  parameter int unsigned ADDR_       = 15,
  parameter int unsigned DATA_       = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ADDR_-1:0] a,
  input  logic [DATA_-1:0] d,
  input  logic             wr,
  input  logic             rd,
  output logic [DATA_-1:0] q,
  output logic             rdy,
  output logic             busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
`ifdef RAM_INIT_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_RESET = S_CLEAR;
  localparam logic       RDY_RST = 1'b0;
`else
  localparam logic [1:0] S_RESET = S_IDLE;
  localparam logic       RDY_RST = 1'b1;
`endif

  logic [DATA_-1:0] mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_-1:0] lat_a_q, lat_a_d;
  logic [DATA_-1:0] lat_d_q, lat_d_d;
  logic             lat_wr_q, lat_wr_d;
  logic [DATA_-1:0] q_q, q_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
`ifdef RAM_INIT_CLEAR_EN
  logic [ADDR_-1:0] clr_a_q, clr_a_d;
`endif

  logic             mem_we_c;
  logic             mem_re_c;
  logic [ADDR_-1:0] mem_a_c;
  logic [DATA_-1:0] mem_wd_c;

  // Next-state, array port selection and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_a_d  = lat_a_q;
    lat_d_d  = lat_d_q;
    lat_wr_d = lat_wr_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;
    mem_a_c  = a;
    mem_wd_c = d;
`ifdef RAM_INIT_CLEAR_EN
    clr_a_d  = clr_a_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (wr || rd) begin
          if (WAIT_STATES == 0) begin
            // Write wins when both requests are present.
            mem_we_c = wr;
            mem_re_c = rd && !wr;
          end else begin
            lat_a_d  = a;
            lat_d_d  = d;
            lat_wr_d = wr;
            cnt_d    = CNT_W'(WAIT_STATES);
            rdy_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d    = cnt_q - 4'd1;
        mem_a_c  = lat_a_q;
        mem_wd_c = lat_d_q;
        if (cnt_q == 4'd1) begin
          mem_we_c = lat_wr_q;
          mem_re_c = !lat_wr_q;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
`ifdef RAM_INIT_CLEAR_EN
      S_CLEAR: begin
        mem_we_c = 1'b1;
        mem_a_c  = clr_a_q;
        mem_wd_c = '0;
        clr_a_d  = clr_a_q + ADDR_'(1);
        if (clr_a_q == ADDR_'(DEPTH - 1)) begin
          clr_a_d = '0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    q_d = mem_re_c ? mem[mem_a_c] : q_q;
  end

  // Control and output registers; a pending latched access is dropped on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      lat_a_q  <= '0;
      lat_d_q  <= '0;
      lat_wr_q <= 1'b0;
      q_q      <= '0;
      rdy_q    <= RDY_RST;
      busy_q   <= !RDY_RST;
`ifdef RAM_INIT_CLEAR_EN
      clr_a_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_a_q  <= lat_a_d;
      lat_d_q  <= lat_d_d;
      lat_wr_q <= lat_wr_d;
      q_q      <= q_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef RAM_INIT_CLEAR_EN
      clr_a_q  <= clr_a_d;
`endif
    end
  end

  // Storage array, never reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_a_c] <= mem_wd_c;
    end
  end

  assign q    = q_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;

endmodule
